motion_segment_stepper: RTL and testbench

Consumes 32-bit motion segments from the motion-segment FIFO and turns each into a train of step pulses plus a direction level for one axis. Sits directly downstream of the FIFO: it pulls one record at a time using the FIFO's `read_en`/`data_out` interface, plays it out, and then fetches the next one. It also keeps a signed absolute position count for host status reporting.

---
 rtl/motion_segment_stepper.sv | 106 ++++++++++
 tb/tb_motion_segment_stepper.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/motion_segment_stepper.sv
// rtl/motion_segment_stepper.sv - pulls 32-bit motion segments from a FIFO and plays them out as step/dir pulses
// Keeps a signed absolute step position for host status.
module motion_segment_stepper #(
  parameter int PulseWidth = 4,
  parameter int DirSetup   = 4,
  parameter int PosBits    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data_available,
  output logic               data_request,
  input  logic [31:0]        data,
  output logic               step_out,
  output logic               dir_out,
  output logic               busy,
  output logic [PosBits-1:0] position
);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SETUP, RUN} state_t;

  localparam logic [15:0] MinP      = 16'(PulseWidth + 1);
  localparam logic [15:0] PwLim     = 16'(PulseWidth);
  localparam logic [15:0] SetupLast = 16'(DirSetup - 1);

  state_t state, state_next;

  logic [15:0] ld_count, ld_period, ld_p, run_count;
  logic [15:0] seg_count, seg_p, pcnt, steps_left, setup_cnt;
  logic        ld_dir, period_end, last_run, enter_run;
  logic [PosBits-1:0] pos_step;

  assign ld_count   = data[15:0];
  assign ld_period  = {1'b0, data[30:16]};
  assign ld_dir     = data[31];
  assign ld_p       = (ld_period > MinP) ? ld_period : MinP;
  assign period_end = (pcnt == seg_p - 16'd1);
  assign last_run   = (state == RUN) && period_end && (steps_left == 16'd1);
  // From LOAD the segment fields are still only on the data bus.
  assign run_count  = (state == LOAD) ? ld_count : seg_count;
  assign enter_run  = (state != RUN) && (state_next == RUN);
  assign pos_step   = dir_out ? position + PosBits'(1) : position - PosBits'(1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (data_available) state_next = FETCH;
      FETCH: state_next = LOAD;
      LOAD:  state_next = (ld_dir != dir_out) ? SETUP : RUN;
      SETUP: if (setup_cnt == SetupLast) state_next = RUN;
      RUN:   if (last_run) state_next = data_available ? FETCH : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_request <= 1'b0;
      busy         <= 1'b0;
      step_out     <= 1'b0;
      dir_out      <= 1'b0;
      position     <= '0;
      seg_count    <= '0;
      seg_p        <= '0;
      pcnt         <= '0;
      steps_left   <= '0;
      setup_cnt    <= '0;
    end else begin
      data_request <= (state_next == FETCH);
      busy         <= (state_next != IDLE);

      if (state == LOAD) begin
        seg_count <= ld_count;
        seg_p     <= ld_p;
        dir_out   <= ld_dir;
        setup_cnt <= '0;
      end
      if (state == SETUP) setup_cnt <= setup_cnt + 16'd1;

      // Pulses and position updates are launched one edge early so they appear registered.
      if (enter_run) begin
        pcnt       <= '0;
        steps_left <= (run_count == 16'd0) ? 16'd1 : run_count;
        step_out   <= (run_count != 16'd0);
        if (run_count != 16'd0) position <= pos_step;
      end else if (state == RUN && !last_run) begin
        if (period_end) begin
          pcnt       <= '0;
          steps_left <= steps_left - 16'd1;
          step_out   <= (seg_count != 16'd0);
          if (seg_count != 16'd0) position <= pos_step;
        end else begin
          pcnt     <= pcnt + 16'd1;
          step_out <= (seg_count != 16'd0) && ((pcnt + 16'd1) < PwLim);
        end
      end else begin
        step_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_motion_segment_stepper.sv
// tb/tb_motion_segment_stepper.sv - directed bench for motion_segment_stepper with a small FIFO model
module tb_motion_segment_stepper;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        data_available = 1'b0;
  logic        data_request;
  logic [31:0] data = '0;
  logic        step_out;
  logic        dir_out;
  logic        busy;
  logic [31:0] position;

  int vectors = 0;
  int miscompares = 0;
  int req_count = 0;
  logic [31:0] fifo_q[$];

  motion_segment_stepper #(.PulseWidth(4), .DirSetup(4), .PosBits(32)) dut (
    .clk(clk), .reset(reset), .data_available(data_available),
    .data_request(data_request), .data(data), .step_out(step_out),
    .dir_out(dir_out), .busy(busy), .position(position)
  );

  always #5 clk = ~clk;

  // FIFO model: pops on a request, word valid during the following cycle.
  always @(negedge clk) begin
    if (data_request) begin
      req_count++;
      if (fifo_q.size() != 0) data = fifo_q.pop_front();
    end
    data_available = (fifo_q.size() != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (data_request !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_req_latency"}, 32'(n), 32'd1);
    check({tag, "_fetch_busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic run_check(input string tag, input int p, input int cnt, input int pos0, input int dlt);
    int n;
    n = p * ((cnt == 0) ? 1 : cnt);
    for (int k = 0; k < n; k++) begin
      check({tag, "_step"}, {31'd0, step_out}, (cnt > 0 && (k % p) < 4) ? 32'd1 : 32'd0);
      check({tag, "_pos"}, position, (cnt > 0) ? 32'(pos0 + dlt * (k / p + 1)) : 32'(pos0));
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    tick();
    tick();
    check("rst_req", {31'd0, data_request}, 32'd0);
    check("rst_step", {31'd0, step_out}, 32'd0);
    check("rst_dir", {31'd0, dir_out}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_pos", position, 32'd0);
    reset = 1'b0;

    // Single segment: count=3 period=10 dir=-
    fifo_q.push_back(32'h000A_0003);
    wait_req("seg1");
    tick();
    check("seg1_load_step", {31'd0, step_out}, 32'd0);
    check("seg1_load_req", {31'd0, data_request}, 32'd0);
    tick();
    run_check("seg1", 10, 3, 0, -1);
    check("seg1_end_busy", {31'd0, busy}, 32'd0);
    check("seg1_end_pos", position, 32'hFFFF_FFFD);
    check("seg1_reqs", 32'(req_count), 32'd1);

    // Period clamp: period=1 becomes 5
    fifo_q.push_back(32'h0001_0002);
    wait_req("clamp");
    tick();
    tick();
    run_check("clamp", 5, 2, -3, -1);
    check("clamp_end_busy", {31'd0, busy}, 32'd0);
    check("clamp_end_pos", position, 32'hFFFF_FFFB);

    // Direction change from reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("dir_rst_pos", position, 32'd0);
    fifo_q.push_back(32'h8008_0001);
    wait_req("dir");
    tick();
    check("dir_load_dir", {31'd0, dir_out}, 32'd0);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("dir_setup_dir", {31'd0, dir_out}, 32'd1);
      check("dir_setup_step", {31'd0, step_out}, 32'd0);
      check("dir_setup_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    run_check("dir", 8, 1, 0, 1);
    check("dir_end_busy", {31'd0, busy}, 32'd0);
    check("dir_end_pos", position, 32'd1);

    // Dwell: count=0 period=7, same direction
    fifo_q.push_back(32'h8007_0000);
    wait_req("dwell");
    tick();
    check("dwell_load_busy", {31'd0, busy}, 32'd1);
    tick();
    run_check("dwell", 7, 0, 1, 0);
    check("dwell_end_busy", {31'd0, busy}, 32'd0);
    check("dwell_end_pos", position, 32'd1);

    // Back-to-back segments
    reset = 1'b1;
    tick();
    reset = 1'b0;
    fifo_q.push_back(32'h0006_0001);
    fifo_q.push_back(32'h0006_0001);
    wait_req("b2b");
    tick();
    tick();
    run_check("b2b_a", 6, 1, 0, -1);
    check("b2b_fetch2_req", {31'd0, data_request}, 32'd1);
    check("b2b_fetch2_step", {31'd0, step_out}, 32'd0);
    tick();
    check("b2b_load2_req", {31'd0, data_request}, 32'd0);
    check("b2b_load2_step", {31'd0, step_out}, 32'd0);
    tick();
    run_check("b2b_b", 6, 1, -1, -1);
    check("b2b_end_busy", {31'd0, busy}, 32'd0);
    check("b2b_end_pos", position, 32'hFFFF_FFFE);
    check("b2b_reqs", 32'(req_count), 32'd6);

    // Reset mid-RUN, FIFO still holding a segment
    fifo_q.push_back(32'h000A_0005);
    fifo_q.push_back(32'h0006_0001);
    wait_req("mid");
    tick();
    tick();
    check("mid_run_step", {31'd0, step_out}, 32'd1);
    check("mid_run_pos", position, 32'hFFFF_FFFD);
    tick();
    check("mid_run_step2", {31'd0, step_out}, 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_step", {31'd0, step_out}, 32'd0);
    check("mid_rst_dir", {31'd0, dir_out}, 32'd0);
    check("mid_rst_pos", position, 32'd0);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_req", {31'd0, data_request}, 32'd0);
    tick();
    check("mid_rst2_req", {31'd0, data_request}, 32'd0);
    check("mid_rst2_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();
    check("mid_refetch_req", {31'd0, data_request}, 32'd1);
    tick();
    tick();
    run_check("mid_next", 6, 1, 0, -1);
    check("mid_end_busy", {31'd0, busy}, 32'd0);
    check("mid_end_pos", position, 32'hFFFF_FFFF);
    check("mid_reqs", 32'(req_count), 32'd8);
    check("mid_fifo_empty", 32'(fifo_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
